// File: rtl/imips_pkg.sv
// imips_pkg: opcode constants and PC-unit state encoding shared by the fetch logic.
package imips_pkg;
  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_J    = 3'b001;
  localparam logic [2:0] OP_JAL  = 3'b010;
  localparam logic [2:0] OP_JR   = 3'b011;
  localparam logic [2:0] OP_BF   = 3'b100;
  localparam logic [2:0] OP_BNF  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;
endpackage

// File: rtl/pc_target.sv
// pc_target: taken decision and redirect target for the instruction in decode.
module pc_target
  import imips_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [25:0] imm,
  input  logic [31:0] dr1,
  input  logic        cfl,
  input  logic [31:0] pc_d,
  output logic        taken,
  output logic [31:0] target
);
  always_comb begin
    taken  = (op == OP_J) || (op == OP_JAL) || (op == OP_JR) ||
             (op == OP_BF && cfl) || (op == OP_BNF && !cfl);
    target = (op == OP_J || op == OP_JAL) ? {pc_d[31:26], imm} :
             (op == OP_JR) ? dr1 :
             pc_d + 32'd1 + {{16{imm[15]}}, imm[15:0]};
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch address generation with redirect flush, halt/resume and stall.
module pc_unit
  import imips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  OP,
  input  logic [25:0] IMM,
  input  logic [31:0] DR1,
  input  logic        CFL,
  input  logic        STALL,
  input  logic        RESUME,
  output logic [31:0] PC,
  output logic [31:0] DJ,
  output logic [1:0]  EW,
  output logic        FLUSH,
  output logic        HLT
);
  state_t state, state_n;
  logic [31:0] pc, pc_d, pc_n, pc_d_n, target;
  logic taken, link;
  pc_target u_target (
    .op(OP), .imm(IMM), .dr1(DR1), .cfl(CFL), .pc_d(pc_d),
    .taken(taken), .target(target)
  );
  always_comb begin
    pc_n    = pc;
    pc_d_n  = pc_d;
    state_n = state;
    if (!STALL) begin
      pc_d_n = pc;
      if (state == S_FLUSH) begin
        pc_n    = pc + 32'd1;
        state_n = S_RUN;
      end else if (state == S_HALT) begin
        state_n = RESUME ? S_RUN : S_HALT;
      end else if (OP == OP_HALT) begin
        state_n = S_HALT;
      end else if (taken) begin
        pc_n    = target;
        state_n = S_FLUSH;
      end else begin
        pc_n = pc + 32'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      pc_d  <= RESET_PC;
      state <= S_FLUSH;
    end else begin
      pc    <= pc_n;
      pc_d  <= pc_d_n;
      state <= state_n;
    end
  end
  always_comb begin
    link  = (state == S_RUN) && !STALL && (OP == OP_JAL);
    PC    = pc;
    DJ    = link ? pc_d + 32'd1 : 32'd0;
    EW    = link ? 2'b10 : 2'b00;
    FLUSH = (state == S_FLUSH);
    HLT   = (state == S_HALT);
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenario checks for pc_unit at RESET_PC 0 and all-ones.
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] OP = 3'b000;
  logic [25:0] IMM = '0;
  logic [31:0] DR1 = '0;
  logic CFL = 1'b0, STALL = 1'b0, RESUME = 1'b0;
  logic [31:0] pc0, dj0, pc1, dj1;
  logic [1:0] ew0, ew1;
  logic fl0, hl0, fl1, hl1;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  pc_unit #(.RESET_PC(32'h0000_0000)) u0 (
    .clk(clk), .rst(rst), .OP(OP), .IMM(IMM), .DR1(DR1), .CFL(CFL), .STALL(STALL),
    .RESUME(RESUME), .PC(pc0), .DJ(dj0), .EW(ew0), .FLUSH(fl0), .HLT(hl0)
  );
  pc_unit #(.RESET_PC(32'hFFFF_FFFF)) u1 (
    .clk(clk), .rst(rst), .OP(OP), .IMM(IMM), .DR1(DR1), .CFL(CFL), .STALL(STALL),
    .RESUME(RESUME), .PC(pc1), .DJ(dj1), .EW(ew1), .FLUSH(fl1), .HLT(hl1)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; OP = 3'b000; tick();
    checks++; if (pc0 !== 32'd0) begin fails++; $display("FAIL reset_pc got %h exp %h", pc0, 32'd0); end
    checks++; if (fl0 !== 1'b1 || hl0 !== 1'b0) begin fails++; $display("FAIL reset_flags got fl=%b hlt=%b exp fl=1 hlt=0", fl0, hl0); end
    checks++; if (ew0 !== 2'b00 || dj0 !== 32'd0) begin fails++; $display("FAIL reset_link got ew=%b dj=%h exp ew=00 dj=0", ew0, dj0); end
    checks++; if (pc1 !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_pc_hi got %h exp ffffffff", pc1); end
    rst = 1'b0;
  endtask
  task automatic test_seq();
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++; if (pc0 !== 32'(i) || fl0 !== 1'b0 || ew0 !== 2'b00) begin fails++; $display("FAIL seq_%0d got pc=%h fl=%b ew=%b exp pc=%h fl=0 ew=00", i, pc0, fl0, ew0, 32'(i)); end
    end
  endtask
  task automatic test_jal();
    OP = 3'b010; IMM = 26'h40; #1;
    checks++; if (ew0 !== 2'b10 || dj0 !== 32'd6) begin fails++; $display("FAIL jal_link got ew=%b dj=%h exp ew=10 dj=6", ew0, dj0); end
    tick();
    checks++; if (pc0 !== 32'h40 || fl0 !== 1'b1 || ew0 !== 2'b00) begin fails++; $display("FAIL jal_redirect got pc=%h fl=%b ew=%b exp pc=40 fl=1 ew=00", pc0, fl0, ew0); end
    OP = 3'b000; tick();
    checks++; if (pc0 !== 32'h41 || fl0 !== 1'b0) begin fails++; $display("FAIL jal_resume got pc=%h fl=%b exp pc=41 fl=0", pc0, fl0); end
  endtask
  task automatic test_branch();
    OP = 3'b001; IMM = 26'd10; tick(); OP = 3'b000; tick();
    OP = 3'b100; IMM = 26'h000FFFD; CFL = 1'b1; tick();
    checks++; if (pc0 !== 32'd8 || fl0 !== 1'b1) begin fails++; $display("FAIL bf_taken got pc=%h fl=%b exp pc=8 fl=1", pc0, fl0); end
    OP = 3'b000; tick();
    OP = 3'b001; IMM = 26'd10; tick(); OP = 3'b000; tick();
    OP = 3'b100; IMM = 26'h000FFFD; CFL = 1'b0; tick();
    checks++; if (pc0 !== 32'd12 || fl0 !== 1'b0) begin fails++; $display("FAIL bf_not_taken got pc=%h fl=%b exp pc=c fl=0", pc0, fl0); end
    OP = 3'b101; IMM = 26'd5; CFL = 1'b0; tick();
    checks++; if (pc0 !== 32'd17 || fl0 !== 1'b1) begin fails++; $display("FAIL bnf_taken got pc=%h fl=%b exp pc=11 fl=1", pc0, fl0); end
    OP = 3'b000; tick();
  endtask
  task automatic test_jr_stall();
    OP = 3'b010; STALL = 1'b1; #1;
    checks++; if (ew0 !== 2'b00 || dj0 !== 32'd0) begin fails++; $display("FAIL stall_jal got ew=%b dj=%h exp ew=00 dj=0", ew0, dj0); end
    OP = 3'b011; DR1 = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc0 !== 32'd18 || ew0 !== 2'b00 || fl0 !== 1'b0) begin fails++; $display("FAIL stall_hold_%0d got pc=%h ew=%b fl=%b exp pc=12 ew=00 fl=0", i, pc0, ew0, fl0); end
    end
    STALL = 1'b0; tick();
    checks++; if (pc0 !== 32'h100 || fl0 !== 1'b1) begin fails++; $display("FAIL jr_redirect got pc=%h fl=%b exp pc=100 fl=1", pc0, fl0); end
    STALL = 1'b1; tick();
    checks++; if (pc0 !== 32'h100 || fl0 !== 1'b1) begin fails++; $display("FAIL stall_in_flush got pc=%h fl=%b exp pc=100 fl=1", pc0, fl0); end
    STALL = 1'b0; OP = 3'b000; tick();
    checks++; if (pc0 !== 32'h101 || fl0 !== 1'b0) begin fails++; $display("FAIL flush_exit got pc=%h fl=%b exp pc=101 fl=0", pc0, fl0); end
  endtask
  task automatic test_halt();
    OP = 3'b001; IMM = 26'd7; tick(); OP = 3'b000; tick();
    OP = 3'b110; tick();
    checks++; if (pc0 !== 32'd8 || hl0 !== 1'b1) begin fails++; $display("FAIL halt_enter got pc=%h hlt=%b exp pc=8 hlt=1", pc0, hl0); end
    OP = 3'b010;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pc0 !== 32'd8 || hl0 !== 1'b1 || ew0 !== 2'b00) begin fails++; $display("FAIL halt_hold_%0d got pc=%h hlt=%b ew=%b exp pc=8 hlt=1 ew=00", i, pc0, hl0, ew0); end
    end
    STALL = 1'b1; RESUME = 1'b1; tick();
    checks++; if (hl0 !== 1'b1) begin fails++; $display("FAIL halt_stall_resume got hlt=%b exp 1", hl0); end
    STALL = 1'b0; tick();
    checks++; if (hl0 !== 1'b0 || pc0 !== 32'd8) begin fails++; $display("FAIL resume got hlt=%b pc=%h exp hlt=0 pc=8", hl0, pc0); end
    RESUME = 1'b0; OP = 3'b000; tick();
    checks++; if (pc0 !== 32'd9) begin fails++; $display("FAIL resume_advance got pc=%h exp 9", pc0); end
    RESUME = 1'b1; tick();
    checks++; if (pc0 !== 32'd10 || hl0 !== 1'b0) begin fails++; $display("FAIL resume_in_run got pc=%h hlt=%b exp pc=a hlt=0", pc0, hl0); end
    RESUME = 1'b0;
  endtask
  task automatic test_wrap();
    OP = 3'b110; tick();
    checks++; if (hl0 !== 1'b1) begin fails++; $display("FAIL halt_again got hlt=%b exp 1", hl0); end
    rst = 1'b1; STALL = 1'b1; OP = 3'b010; tick();
    checks++; if (pc0 !== 32'd0 || hl0 !== 1'b0 || fl0 !== 1'b1) begin fails++; $display("FAIL rst_in_halt got pc=%h hlt=%b fl=%b exp pc=0 hlt=0 fl=1", pc0, hl0, fl0); end
    checks++; if (pc1 !== 32'hFFFF_FFFF || hl1 !== 1'b0 || fl1 !== 1'b1) begin fails++; $display("FAIL rst_in_halt_hi got pc=%h hlt=%b fl=%b exp pc=ffffffff hlt=0 fl=1", pc1, hl1, fl1); end
    checks++; if (ew0 !== 2'b00 || dj0 !== 32'd0) begin fails++; $display("FAIL rst_link got ew=%b dj=%h exp ew=00 dj=0", ew0, dj0); end
    rst = 1'b0; STALL = 1'b0; OP = 3'b000; tick();
    checks++; if (pc1 !== 32'd0 || pc0 !== 32'd1) begin fails++; $display("FAIL wrap got pc1=%h pc0=%h exp pc1=0 pc0=1", pc1, pc0); end
    OP = 3'b010; IMM = 26'd3; #1;
    checks++; if (dj1 !== 32'd0 || ew1 !== 2'b10 || dj0 !== 32'd1) begin fails++; $display("FAIL wrap_link got dj1=%h ew1=%b dj0=%h exp dj1=0 ew1=10 dj0=1", dj1, ew1, dj0); end
    tick();
    checks++; if (pc1 !== 32'hFC00_0003 || pc0 !== 32'd3) begin fails++; $display("FAIL jal_region got pc1=%h pc0=%h exp pc1=fc000003 pc0=3", pc1, pc0); end
  endtask
  initial begin
    test_reset();
    test_seq();
    test_jal();
    test_branch();
    test_jr_stall();
    test_halt();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
